// File: rtl/dma_multi_ch.sv
// dma_multi_ch: multi-channel word-copy DMA with round-robin engine; define DMA_IRQ_EN for per-channel irq_en and irq output
module dma_multi_ch #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [7:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ready,
    output logic              busy,
    output logic              irq
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] src [NUM_CH];
    logic [ADDR_W-1:0] dst [NUM_CH];
    logic [LEN_W-1:0]  len [NUM_CH];
    logic [NUM_CH-1:0] busy_r, done_r, ien_r;
    logic [CW-1:0]     cur, last, grant, idx, wch;
    logic [31:0]       data_q;
    logic [LEN_W-1:0]  rem_nxt;
    logic              ch_ok, ctrl_we, start, wr_done;

    assign wch = cfg_addr[4 +: CW];
    assign ch_ok = {1'b0, cfg_addr[7:4]} < 5'(NUM_CH);
    assign ctrl_we = cfg_we && ch_ok && cfg_addr[3:2] == 2'd3;
    assign start = ctrl_we && cfg_wdata[0] && !busy_r[wch];
    assign rem_nxt = len[cur] - LEN_W'(4);
    assign wr_done = state == WRITE && m_ready;
    assign busy = |busy_r;
    assign irq = |(done_r & ien_r);
    assign m_req = state != IDLE;
    assign m_we = state == WRITE;
    assign m_addr = state == READ ? src[cur] : state == WRITE ? dst[cur] : '0;
    assign m_wdata = state == WRITE ? data_q : '0;

    // round-robin: nearest busy channel after the last served one wins
    always_comb begin
        grant = last;
        idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = CW'((int'(last) + i) % NUM_CH);
            if (busy_r[idx]) grant = idx;
        end
    end

    // engine next state: one word per IDLE -> READ -> WRITE pass
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = busy ? READ : IDLE;
            READ:    state_nxt = m_ready ? WRITE : READ;
            WRITE:   state_nxt = m_ready ? IDLE : WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    // engine state, granted channel and latched read word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur <= '0;
            last <= CW'(NUM_CH - 1);
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && busy) begin
                cur <= grant;
                last <= grant;
            end
            if (state == READ && m_ready) data_q <= m_rdata;
        end
    end

    // channel registers; later assignments win, so engine done beats W1C
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src[i] <= '0;
                dst[i] <= '0;
                len[i] <= '0;
            end
            busy_r <= '0;
            done_r <= '0;
        end else begin
            if (cfg_we && ch_ok && !busy_r[wch]) begin
                case (cfg_addr[3:2])
                    2'd0:    src[wch] <= ADDR_W'(cfg_wdata);
                    2'd1:    dst[wch] <= ADDR_W'(cfg_wdata);
                    2'd2:    len[wch] <= LEN_W'(cfg_wdata);
                    default: ;
                endcase
            end
            if (ctrl_we && cfg_wdata[2]) done_r[wch] <= 1'b0;
            if (start) begin
                len[wch] <= {len[wch][LEN_W-1:2], 2'b00};
                busy_r[wch] <= |len[wch][LEN_W-1:2];
                done_r[wch] <= ~|len[wch][LEN_W-1:2];
            end
            if (wr_done) begin
                src[cur] <= src[cur] + ADDR_W'(4);
                dst[cur] <= dst[cur] + ADDR_W'(4);
                len[cur] <= rem_nxt;
                if (rem_nxt == '0) begin
                    busy_r[cur] <= 1'b0;
                    done_r[cur] <= 1'b1;
                end
            end
        end
    end

`ifdef DMA_IRQ_EN
    // irq_en is writable at any time, even while the channel is busy
    always_ff @(posedge clk) begin
        if (!rst_n) ien_r <= '0;
        else if (ctrl_we) ien_r[wch] <= cfg_wdata[1];
    end
`else
    assign ien_r = '0;
`endif

    // combinational register read; unimplemented channels read 0
    always_comb begin
        cfg_rdata = '0;
        if (cfg_re && ch_ok) begin
            case (cfg_addr[3:2])
                2'd0:    cfg_rdata = 32'(src[wch]);
                2'd1:    cfg_rdata = 32'(dst[wch]);
                2'd2:    cfg_rdata = 32'(len[wch]);
                default: cfg_rdata = {29'b0, ien_r[wch], done_r[wch], busy_r[wch]};
            endcase
        end
    end
endmodule

// File: tb/tb_dma_multi_ch.sv
// tb_dma_multi_ch: directed self-checking bench for dma_multi_ch with a zero-wait word memory
module tb_dma_multi_ch;
`ifdef DMA_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    logic        clk = 0, rst_n = 0, cfg_we = 0, cfg_re = 0;
    logic [7:0]  cfg_addr = 0;
    logic [31:0] cfg_wdata = 0, cfg_rdata, m_addr, m_wdata, m_rdata;
    logic        m_req, m_we, m_ready, busy, irq;
    logic        ready_en = 1, fill = 0;
    logic [31:0] mem [1024];
    logic [31:0] rd_log [$];
    int          acc_cnt = 0, req_cnt = 0;
    int          errors = 0, checks = 0;

    dma_multi_ch dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;
    assign m_ready = ready_en;
    assign m_rdata = mem[m_addr[11:2]];

    // memory, bus access counters and read-address log
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 + 32'(i);
        end else if (m_req && m_we && m_ready) begin
            mem[m_addr[11:2]] <= m_wdata;
        end
        if (m_req) req_cnt <= req_cnt + 1;
        if (m_req && m_ready) acc_cnt <= acc_cnt + 1;
        if (m_req && m_ready && !m_we) rd_log.push_back(m_addr);
    end

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    task automatic mem_fill();
        @(negedge clk) fill = 1;
        @(negedge clk) fill = 0;
    endtask

    task automatic cfg_write(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1;
        cfg_addr = 8'(ch * 16 + r * 4);
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic cfg_read(input int ch, input int r, output logic [31:0] d);
        cfg_re = 1;
        cfg_addr = 8'(ch * 16 + r * 4);
        #1 d = cfg_rdata;
        cfg_re = 0;
    endtask

    task automatic wait_idle(input int max, output int cyc);
        cyc = 0;
        while (busy && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int bad;
        rst_n = 0;
        mem_fill();
        repeat (2) @(negedge clk);
        checks++;
        if ({m_req, m_we, busy, irq} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs: req/we/busy/irq=%b expected 0000", {m_req, m_we, busy, irq});
        end
        checks++;
        if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0", m_addr, m_wdata);
        end
        rst_n = 1;
        bad = 0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 4; r++) begin
                cfg_read(c, r, d);
                if (d !== 32'h0) bad++;
            end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_regs: %0d nonzero registers, expected 0", bad);
        end
        cfg_write(2, 0, 32'h1234);
        cfg_write(2, 2, 32'h40);
        cfg_write(2, 3, 32'h1);
        cfg_read(2, 0, d);
        checks++;
        if (d !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_channel: rdata=%h busy=%b expected 0/0", d, busy);
        end
    endtask

    task automatic test_copy();
        logic [31:0] d;
        int cyc, bad, a0;
        cfg_write(0, 0, 32'h200);
        cfg_write(0, 1, 32'h300);
        cfg_write(0, 2, 32'h100);
        a0 = acc_cnt;
        cfg_write(0, 3, 32'h1);
        cfg_read(0, 3, d);
        checks++;
        if (d !== 32'h1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: ctrl=%h busy=%b expected 1/1", d, busy);
        end
        cfg_write(0, 0, 32'hFFC);
        repeat (4) @(negedge clk);
        cfg_read(0, 2, d);
        checks++;
        if (d !== 32'hF8) begin
            errors++;
            $display("FAIL live_len: got %h expected 000000f8", d);
        end
        cfg_read(0, 0, d);
        checks++;
        if (d !== 32'h208) begin
            errors++;
            $display("FAIL live_src: got %h expected 00000208", d);
        end
        wait_idle(250, cyc);
        checks++;
        if (busy !== 1'b0 || cyc > 200) begin
            errors++;
            $display("FAIL copy_time: busy=%b cycles=%0d expected 0 within 200", busy, cyc);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[192 + i] !== init_val(128 + i)) bad++;
        checks++;
        if (bad !== 0 || mem[256] !== init_val(256)) begin
            errors++;
            $display("FAIL copy_data: %0d bad words, word after=%h expected 0 and %h", bad, mem[256], init_val(256));
        end
        checks++;
        if (acc_cnt - a0 !== 128) begin
            errors++;
            $display("FAIL copy_accesses: got %0d expected 128", acc_cnt - a0);
        end
        cfg_read(0, 3, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL copy_done: ctrl=%h expected 00000002", d);
        end
        cfg_read(0, 0, d);
        checks++;
        if (d !== 32'h300) begin
            errors++;
            $display("FAIL busy_write_ignored: src=%h expected 00000300", d);
        end
    endtask

    task automatic test_interleave();
        logic [31:0] exp_rd [8] = '{32'h0, 32'h40, 32'h4, 32'h44, 32'h8, 32'h48, 32'hC, 32'h4C};
        logic [31:0] d0, d1;
        int cyc, bad, n0;
        mem_fill();
        cfg_write(0, 0, 32'h000);
        cfg_write(0, 1, 32'h100);
        cfg_write(0, 2, 32'h10);
        cfg_write(1, 0, 32'h040);
        cfg_write(1, 1, 32'h140);
        cfg_write(1, 2, 32'h10);
        n0 = rd_log.size();
        cfg_write(0, 3, 32'h1);
        cfg_write(1, 3, 32'h1);
        wait_idle(100, cyc);
        checks++;
        if (rd_log.size() - n0 !== 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL interleave_count: reads=%0d busy=%b expected 8/0", rd_log.size() - n0, busy);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) if (n0 + i < rd_log.size() && rd_log[n0 + i] !== exp_rd[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL interleave_order: %0d reads out of order, expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem[64 + i] !== init_val(i)) bad++;
            if (mem[80 + i] !== init_val(16 + i)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL interleave_data: %0d bad words, expected 0", bad);
        end
        cfg_read(0, 3, d0);
        cfg_read(1, 3, d1);
        checks++;
        if (d0 !== 32'h2 || d1 !== 32'h2) begin
            errors++;
            $display("FAIL interleave_done: ctrl0=%h ctrl1=%h expected 2/2", d0, d1);
        end
    endtask

    task automatic test_wait_state();
        int cyc, bad, a0;
        cfg_write(0, 0, 32'h400);
        cfg_write(0, 1, 32'h500);
        cfg_write(0, 2, 32'h4);
        ready_en = 0;
        a0 = acc_cnt;
        cfg_write(0, 3, 32'h1);
        cyc = 0;
        while (!m_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (m_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: m_req=%b expected 1", m_req);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({m_req, m_we} !== 2'b10 || m_addr !== 32'h400) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wait_stable: %0d unstable cycles, expected 0", bad);
        end
        ready_en = 1;
        wait_idle(20, cyc);
        checks++;
        if (busy !== 1'b0 || acc_cnt - a0 !== 2) begin
            errors++;
            $display("FAIL wait_accesses: busy=%b accesses=%0d expected 0/2", busy, acc_cnt - a0);
        end
        checks++;
        if (mem[320] !== init_val(256)) begin
            errors++;
            $display("FAIL wait_data: got %h expected %h", mem[320], init_val(256));
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] d;
        int r0;
        cfg_write(1, 3, 32'h4);
        cfg_read(1, 3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL w1c_done: ctrl=%h expected 00000000", d);
        end
        r0 = req_cnt;
        cfg_write(1, 2, 32'h3);
        cfg_write(1, 3, 32'h1);
        cfg_read(1, 3, d);
        checks++;
        if (d !== 32'h2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: ctrl=%h busy=%b expected 2/0", d, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (req_cnt !== r0) begin
            errors++;
            $display("FAIL zero_len_req: %0d request cycles, expected 0", req_cnt - r0);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int cyc;
        cfg_write(0, 0, 32'h800);
        cfg_write(0, 1, 32'h900);
        cfg_write(0, 2, 32'h8);
        cfg_write(0, 3, 32'h3);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_start: irq=%b expected 0", irq);
        end
        wait_idle(30, cyc);
        checks++;
        if (irq !== IRQ_ON || busy !== 1'b0) begin
            errors++;
            $display("FAIL irq_done: irq=%b busy=%b expected %b/0", irq, busy, IRQ_ON);
        end
        cfg_read(0, 3, d);
        checks++;
        if (d !== {29'b0, IRQ_ON, 2'b10}) begin
            errors++;
            $display("FAIL irq_ctrl: ctrl=%h expected %h", d, {29'b0, IRQ_ON, 2'b10});
        end
        checks++;
        if (mem[576] !== init_val(512) || mem[577] !== init_val(513)) begin
            errors++;
            $display("FAIL irq_data: got %h %h expected %h %h", mem[576], mem[577], init_val(512), init_val(513));
        end
        cfg_write(0, 3, 32'h6);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int cyc, bad;
        mem_fill();
        cfg_write(1, 0, 32'h123);
        cfg_write(0, 0, 32'hA00);
        cfg_write(0, 1, 32'hB00);
        cfg_write(0, 2, 32'h40);
        cfg_write(0, 3, 32'h1);
        cyc = 0;
        while (!(m_req && m_we && m_addr == 32'hB28) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(m_req && m_we && m_addr == 32'hB28)) begin
            errors++;
            $display("FAIL mid_reach: addr=%h we=%b expected b28/1", m_addr, m_we);
        end
        ready_en = 0;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: m_req=%b busy=%b expected 0/0", m_req, busy);
        end
        bad = 0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 4; r++) begin
                cfg_read(c, r, d);
                if (d !== 32'h0) bad++;
            end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_regs: %0d nonzero registers, expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[704 + i] !== init_val(i < 10 ? 640 + i : 704 + i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_data: %0d bad words, expected 0", bad);
        end
        ready_en = 1;
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_copy();
        test_interleave();
        test_wait_state();
        test_zero_len();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_multi_ch.md
DMA_MULTI_CH -- requirements
Module: dma_multi_ch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent channels, 1..16.
REQ-002 SHALL have parameter ADDR_W, default 32: master address width.
REQ-003 SHALL have parameter LEN_W, default 16: byte-length register width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports cfg_we / cfg_re  input  1 each  MMIO write / read strobe.
REQ-007 SHALL have port cfg_addr  input  8  register offset: [7:4] channel, [3:2] register.
REQ-008 SHALL have port cfg_wdata  input  32  write data.
REQ-009 SHALL have port cfg_rdata  output  32  combinational read data, valid in the cycle cfg_re is high.
REQ-010 SHALL have ports m_req, m_we  output  1 each  master request / write qualifier.
REQ-011 SHALL have ports m_addr (output, ADDR_W) and m_wdata (output, 32)  master address and write data.
REQ-012 SHALL have ports m_rdata (input, 32) and m_ready (input, 1)  read data and handshake accept.
REQ-013 SHALL have port busy  output  1  OR of all channel busy bits.
REQ-014 SHALL have port irq  output  1  level interrupt (see Configuration).

Function
REQ-015 Per-channel registers: 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL; write CTRL bit0=1 starts, bit2=1 clears done (W1C); CTRL read returns {29'b0, irq_en, done, busy}.
REQ-016 SRC/DST/LEN reads SHALL return live current address / remaining bytes during a transfer.
REQ-017 Writes to SRC, DST, LEN or start SHALL be ignored while that channel is busy; channel index >= NUM_CH: writes ignored, reads return 0.
REQ-018 Start SHALL set busy next cycle, clear done; LEN low two bits ignored (word transfers only).
REQ-019 Start with LEN[LEN_W-1:2]==0 SHALL set done (busy stays 0) next cycle with no master access.
REQ-020 Engine FSM: IDLE -> READ -> WRITE -> IDLE; one word moved per pass.
REQ-021 IDLE: round-robin grant among busy channels, starting after last-served channel; one cycle, no master access.
REQ-022 READ: m_req=1, m_we=0, m_addr=src_cur; hold until m_ready; on m_ready latch m_rdata, go WRITE.
REQ-023 WRITE: m_req=1, m_we=1, m_addr=dst_cur, m_wdata=latched word; on m_ready src+=4, dst+=4, rem-=4, go IDLE.
REQ-024 When rem reaches 0 in WRITE, that channel SHALL clear busy and set done in the same edge.
REQ-025 m_addr, m_we, m_wdata SHALL be stable while m_req=1 and m_ready=0.
REQ-026 Channels interleave per word; a single busy channel sustains one word per 3 cycles with zero-wait m_ready.
REQ-027 Done set by engine and W1C in same cycle: done set wins.
REQ-028 Address arithmetic wraps modulo 2^ADDR_W; no error flag.

Reset
REQ-029 On rst_n=0: all SRC/DST/LEN/CTRL = 0, FSM = IDLE, round-robin pointer = channel NUM_CH-1, m_req=m_we=0, m_addr=m_wdata=0, busy=irq=0.
REQ-030 Reset mid-transfer SHALL abort immediately; m_req low in the first cycle after reset; partial writes are not rolled back.

Configuration
REQ-031 Macro DMA_IRQ_EN defined: CTRL bit1 is irq_en (R/W), irq = OR over channels of (done & irq_en).
REQ-032 DMA_IRQ_EN undefined: CTRL bit1 reads 0, writes ignored, irq tied 0; all other behaviour identical.

Verification
REQ-033 Ch0 SRC=0x200, DST=0x300, LEN=0x100, start; zero-wait memory -> 64 words copied, ch0 done, busy=0 within 200 cycles.
REQ-034 Ch0 and ch1 started same cycle, LEN=0x10 each -> master accesses alternate ch0/ch1 per word, both done at end.
REQ-035 m_ready held low 5 cycles during READ -> m_addr/m_we stable, no extra access, data intact.
REQ-036 Start with LEN=0x3 -> done=1 next cycle, m_req never asserted.
REQ-037 DMA_IRQ_EN set, irq_en=1, LEN=0x8 -> irq rises with done; W1C bit2 -> irq falls next cycle; macro undefined -> irq stays 0.
REQ-038 rst_n low during WRITE of word 10 -> m_req=0 next cycle, all registers read 0, DST words 0..9 copied, rest untouched.
